// File: rtl/lc3b_types.sv
// ----------------------------------------------------------------------------
// lc3b_types
// Shared definitions for the pseudo-LRU cache controller:
//   - cache_state_e   : controller FSM states
//   - plru_victim()   : walk the heap-ordered tree from the root to the victim
//   - plru_update()   : point every node on an accessed way's path away from it
//   - plru_ways_legal(): legality check of a WAYS value against PLRU_LEGAL_WAYS
// Tree layout: node 0 is the root, node n has children 2n+1 / 2n+2, leaves are
// ways 0..WAYS-1 left to right. A node bit of 1 means "victim is on the right".
// Functions operate on the widest supported tree (16 ways, 15 node bits);
// callers zero-extend narrower trees and pass the number of levels.
// Optional feature macro: PLRU_VICTIM_EVICT_EN (adds the EVICT state).
// ----------------------------------------------------------------------------
package lc3b_types;

  localparam int unsigned PLRU_MAX_WAYS = 16;
  localparam int unsigned PLRU_MAX_LVL  = 4;
  localparam int unsigned PLRU_TREE_W   = PLRU_MAX_WAYS - 1;

  // Bit n set <=> WAYS == n is a supported configuration (2, 4, 8, 16).
  localparam logic [PLRU_MAX_WAYS:0] PLRU_LEGAL_WAYS = 17'b1_0000_0001_0001_0100;

  typedef logic [PLRU_TREE_W-1:0]  plru_tree_t;
  typedef logic [PLRU_MAX_LVL-1:0] plru_way_t;

  typedef enum logic [2:0] {
    PROCESS,
    STALL,
    WRITE_BACK,
`ifdef PLRU_VICTIM_EVICT_EN
    EVICT,
`endif
    FETCH
  } cache_state_e;

  function automatic bit plru_ways_legal(input int unsigned ways);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i <= PLRU_MAX_WAYS; i++) begin
      if (i == ways) ok = PLRU_LEGAL_WAYS[i];
    end
    return ok;
  endfunction

  function automatic plru_way_t plru_victim(input plru_tree_t tree,
                                            input int unsigned levels);
    int unsigned node;
    plru_way_t   way;
    node = 0;
    way  = '0;
    for (int unsigned lvl = 0; lvl < PLRU_MAX_LVL; lvl++) begin
      if (lvl < levels) begin
        way  = {way[PLRU_MAX_LVL-2:0], tree[node]};
        node = 2 * node + 1 + (tree[node] ? 1 : 0);
      end
    end
    return way;
  endfunction

  function automatic plru_tree_t plru_update(input plru_tree_t tree,
                                             input plru_way_t way,
                                             input int unsigned levels);
    plru_tree_t  t;
    int unsigned node;
    logic        b;
    t    = tree;
    node = 0;
    for (int unsigned lvl = 0; lvl < PLRU_MAX_LVL; lvl++) begin
      if (lvl < levels) begin
        b       = way[levels-1-lvl];
        t[node] = ~b;
        node    = 2 * node + 1 + (b ? 1 : 0);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// ----------------------------------------------------------------------------
// plru_tree
// Combinational pseudo-LRU tree: victim selection from the current tree and
// the updated tree for an access to i_access_way.
// Ports:
//   i_lru        [WAYS-2:0]       current tree bits
//   i_access_way [log2(WAYS)-1:0] way being accessed
//   o_victim     [log2(WAYS)-1:0] way the tree currently points at
//   o_lru_upd    [WAYS-2:0]       tree bits after the access
// ----------------------------------------------------------------------------
module plru_tree
  import lc3b_types::*;
#(
  parameter int unsigned WAYS = 8
) (
  input  logic [WAYS-2:0]         i_lru,
  input  logic [$clog2(WAYS)-1:0] i_access_way,
  output logic [$clog2(WAYS)-1:0] o_victim,
  output logic [WAYS-2:0]         o_lru_upd
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  plru_tree_t w_tree_full;
  plru_tree_t w_upd_full;
  plru_way_t  w_access_full;
  plru_way_t  w_victim_full;

  always_comb begin
    w_tree_full               = '0;
    w_tree_full[WAYS-2:0]     = i_lru;
    w_access_full             = '0;
    w_access_full[WAY_W-1:0]  = i_access_way;
  end

  assign w_victim_full = plru_victim(w_tree_full, WAY_W);
  assign w_upd_full    = plru_update(w_tree_full, w_access_full, WAY_W);

  assign o_victim  = w_victim_full[WAY_W-1:0];
  assign o_lru_upd = w_upd_full[WAYS-2:0];

  // Padding bits above the configured tree are structurally zero.
  if (WAYS < PLRU_MAX_WAYS) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^{w_upd_full[PLRU_TREE_W-1:WAYS-1],
                            w_victim_full[PLRU_MAX_LVL-1:WAY_W]};
  end

endmodule

// File: rtl/plru_cache_control.sv
// ----------------------------------------------------------------------------
// plru_cache_control
// Set-associative cache controller with tree pseudo-LRU replacement.
// Hits respond combinationally, followed by HIT_STALL idle cycles. Misses
// latch the tree victim, write it back if dirty, then fetch the new line.
// Optional macro PLRU_VICTIM_EVICT_EN: clean valid victims spend one EVICT
// cycle (eviction strobe, victim address) before the fetch.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   mem_read, mem_write / mem_resp   CPU-side request / completion
//   hit_vec, valid_vec, dirty_vec    per-way tag hit, valid, dirty
//   lru_in / lru_out, load_lru       tree bits in / updated / write enable
//   load_td, load_v, load_d          per-way tag+data, valid, dirty loads
//   v_in, d_in                       valid / dirty data to load
//   way_sel                          data-mux way select
//   addr_victim                      1 = victim tag address, 0 = request
//   pmem_read, pmem_write, pmem_resp physical-memory handshake
//   eviction                         victim-transfer strobe
//   hit_count, miss_count            saturating performance counters
// ----------------------------------------------------------------------------
module plru_cache_control
  import lc3b_types::*;
#(
  parameter int unsigned WAYS      = 8,
  parameter int unsigned HIT_STALL = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  output logic                    mem_resp,
  input  logic [WAYS-1:0]         hit_vec,
  input  logic [WAYS-1:0]         valid_vec,
  input  logic [WAYS-1:0]         dirty_vec,
  input  logic [WAYS-2:0]         lru_in,
  output logic [WAYS-2:0]         lru_out,
  output logic                    load_lru,
  output logic [WAYS-1:0]         load_td,
  output logic [WAYS-1:0]         load_v,
  output logic [WAYS-1:0]         load_d,
  output logic                    v_in,
  output logic                    d_in,
  output logic [$clog2(WAYS)-1:0] way_sel,
  output logic                    addr_victim,
  output logic                    pmem_read,
  output logic                    pmem_write,
  input  logic                    pmem_resp,
  output logic                    eviction,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);

  localparam int unsigned WAY_W      = $clog2(WAYS);
  localparam bit          WAYS_LEGAL = plru_ways_legal(WAYS);

  if (!WAYS_LEGAL) begin : g_bad_ways
    $error("plru_cache_control: WAYS must be a power of two in 2..16");
  end

  cache_state_e     r_state, w_state_nxt;
  logic [2:0]       r_stall, w_stall_nxt;
  logic [WAY_W-1:0] r_victim, w_victim_nxt;
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

  logic             w_req;
  logic             w_any_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_tree_victim;
  logic [WAY_W-1:0] w_access_way;
  logic [WAYS-2:0]  w_lru_upd;
  logic             w_miss_evt;

  assign w_req = mem_read ^ mem_write;

  // Lowest-index hitting way wins when hit_vec is not one-hot.
  always_comb begin
    w_hit_way = '0;
    w_any_hit = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (hit_vec[i] && !w_any_hit) begin
        w_hit_way = WAY_W'(i);
        w_any_hit = 1'b1;
      end
    end
  end

  // The same update logic serves hit accesses and fill completion.
  assign w_access_way = (r_state == FETCH) ? r_victim : w_hit_way;

  plru_tree #(
    .WAYS(WAYS)
  ) u_plru_tree (
    .i_lru       (lru_in),
    .i_access_way(w_access_way),
    .o_victim    (w_tree_victim),
    .o_lru_upd   (w_lru_upd)
  );

`ifndef PLRU_VICTIM_EVICT_EN
  logic w_unused_valid;
  assign w_unused_valid = ^valid_vec;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_stall_nxt  = r_stall;
    w_victim_nxt = r_victim;
    w_miss_evt   = 1'b0;
    mem_resp     = 1'b0;
    lru_out      = lru_in;
    load_lru     = 1'b0;
    load_td      = '0;
    load_v       = '0;
    load_d       = '0;
    v_in         = 1'b0;
    d_in         = 1'b0;
    way_sel      = '0;
    addr_victim  = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    eviction     = 1'b0;
    // Outputs are combinational from state, so they are held quiet while
    // reset is asserted rather than relying on the state register alone.
    if (reset_n) begin
      unique case (r_state)
        PROCESS: begin
          if (w_req) begin
            if (w_any_hit) begin
              mem_resp = 1'b1;
              load_lru = 1'b1;
              lru_out  = w_lru_upd;
              way_sel  = w_hit_way;
              if (mem_write) begin
                load_td[w_hit_way] = 1'b1;
                load_d[w_hit_way]  = 1'b1;
                d_in               = 1'b1;
              end
              if (HIT_STALL != 0) begin
                w_state_nxt = STALL;
                w_stall_nxt = 3'(HIT_STALL);
              end
            end else begin
              w_miss_evt   = 1'b1;
              w_victim_nxt = w_tree_victim;
              if (dirty_vec[w_tree_victim]) begin
                w_state_nxt = WRITE_BACK;
              end
`ifdef PLRU_VICTIM_EVICT_EN
              else if (valid_vec[w_tree_victim]) begin
                w_state_nxt = EVICT;
              end
`endif
              else begin
                w_state_nxt = FETCH;
              end
            end
          end
        end
        STALL: begin
          if (r_stall <= 3'd1) begin
            w_state_nxt = PROCESS;
            w_stall_nxt = '0;
          end else begin
            w_stall_nxt = r_stall - 3'd1;
          end
        end
        WRITE_BACK: begin
          pmem_write  = 1'b1;
          eviction    = 1'b1;
          addr_victim = 1'b1;
          way_sel     = r_victim;
          if (pmem_resp) w_state_nxt = FETCH;
        end
`ifdef PLRU_VICTIM_EVICT_EN
        EVICT: begin
          eviction    = 1'b1;
          addr_victim = 1'b1;
          way_sel     = r_victim;
          w_state_nxt = FETCH;
        end
`endif
        FETCH: begin
          pmem_read = 1'b1;
          way_sel   = r_victim;
          if (pmem_resp) begin
            load_td[r_victim] = 1'b1;
            load_v[r_victim]  = 1'b1;
            load_d[r_victim]  = 1'b1;
            v_in              = 1'b1;
            load_lru          = 1'b1;
            lru_out           = w_lru_upd;
            w_state_nxt       = PROCESS;
          end
        end
        default: w_state_nxt = PROCESS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= PROCESS;
      r_stall    <= '0;
      r_victim   <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_stall  <= w_stall_nxt;
      r_victim <= w_victim_nxt;
      if (mem_resp && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_miss_evt && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_plru_cache_control.sv
// ----------------------------------------------------------------------------
// tb_plru_cache_control
// Directed bench for plru_cache_control: an 8-way instance (HIT_STALL=2) and
// a 4-way instance (HIT_STALL=0). Expected values are hand-computed from the
// tree ordering rules. Honours PLRU_VICTIM_EVICT_EN for the 4-way clean
// victim sequence.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_plru_cache_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // 8-way instance
  logic        rd8, wr8, resp8, ldlru8, vin8, din8, addrv8, prd8, pwr8, presp8, ev8;
  logic [7:0]  hit8, val8, dty8, ltd8, lv8, ld8;
  logic [6:0]  lin8, lout8;
  logic [2:0]  ws8;
  logic [31:0] hc8, mc8;

  // 4-way instance
  logic        rd4, wr4, resp4, ldlru4, vin4, din4, addrv4, prd4, pwr4, presp4, ev4;
  logic [3:0]  hit4, val4, dty4, ltd4, lv4, ld4;
  logic [2:0]  lin4, lout4;
  logic [1:0]  ws4;
  logic [7:0]  hc4, mc4;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  plru_cache_control #(
    .WAYS(8), .HIT_STALL(2), .CNT_W(32)
  ) u_dut8 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd8), .mem_write(wr8), .mem_resp(resp8),
    .hit_vec(hit8), .valid_vec(val8), .dirty_vec(dty8), .lru_in(lin8), .lru_out(lout8),
    .load_lru(ldlru8), .load_td(ltd8), .load_v(lv8), .load_d(ld8), .v_in(vin8), .d_in(din8),
    .way_sel(ws8), .addr_victim(addrv8), .pmem_read(prd8), .pmem_write(pwr8),
    .pmem_resp(presp8), .eviction(ev8), .hit_count(hc8), .miss_count(mc8)
  );

  plru_cache_control #(
    .WAYS(4), .HIT_STALL(0), .CNT_W(8)
  ) u_dut4 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd4), .mem_write(wr4), .mem_resp(resp4),
    .hit_vec(hit4), .valid_vec(val4), .dirty_vec(dty4), .lru_in(lin4), .lru_out(lout4),
    .load_lru(ldlru4), .load_td(ltd4), .load_v(lv4), .load_d(ld4), .v_in(vin4), .d_in(din4),
    .way_sel(ws4), .addr_victim(addrv4), .pmem_read(prd4), .pmem_write(pwr4),
    .pmem_resp(presp4), .eviction(ev4), .hit_count(hc4), .miss_count(mc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    rd8 = 0; wr8 = 0; hit8 = '0; val8 = '0; dty8 = '0; lin8 = '0; presp8 = 0;
    rd4 = 0; wr4 = 0; hit4 = '0; val4 = '0; dty4 = '0; lin4 = '0; presp4 = 0;
    #2;

    // Reset: outputs quiet, tree passes through, counters clear.
    rd8 = 1; hit8 = 8'h01; lin8 = 7'h55; #1;
    chk("rst_resp",     32'(resp8),  32'h0);
    chk("rst_ldlru",    32'(ldlru8), 32'h0);
    chk("rst_lru_pass", 32'(lout8),  32'h55);
    chk("rst_hitcnt",   hc8,         32'h0);
    rd8 = 0; hit8 = '0;
    tick(); tick();
    reset_n = 1'b1;

    // Read hit on way 0 with an all-zero tree, then two stall cycles.
    lin8 = '0; rd8 = 1; hit8 = 8'h01; val8 = 8'hFF; #1;
    chk("hit_resp",   32'(resp8),  32'h1);
    chk("hit_ldlru",  32'(ldlru8), 32'h1);
    chk("hit_lru",    32'(lout8),  32'h0B);
    chk("hit_way",    32'(ws8),    32'h0);
    chk("hit_rd_ltd", 32'(ltd8),   32'h0);
    tick();
    chk("stall1_resp", 32'(resp8), 32'h0);
    chk("hit_cnt1",    hc8,        32'h1);
    tick();
    chk("stall2_resp", 32'(resp8), 32'h0);
    tick();
    chk("post_stall_resp", 32'(resp8), 32'h1);
    rd8 = 0; hit8 = '0;
    tick();
    chk("hit_cnt_hold", hc8, 32'h1);

    // Both read and write high: ignored.
    rd8 = 1; wr8 = 1; hit8 = 8'h0C; #1;
    chk("both_resp",  32'(resp8),  32'h0);
    chk("both_ldlru", 32'(ldlru8), 32'h0);
    chk("both_ltd",   32'(ltd8),   32'h0);
    tick();
    chk("both_hc", hc8, 32'h1);
    chk("both_mc", mc8, 32'h0);

    // Write hit, hit_vec=0x0C -> way 2.
    rd8 = 0; #1;
    chk("wr_resp", 32'(resp8), 32'h1);
    chk("wr_way",  32'(ws8),   32'h2);
    chk("wr_ltd",  32'(ltd8),  32'h04);
    chk("wr_ld",   32'(ld8),   32'h04);
    chk("wr_lv",   32'(lv8),   32'h0);
    chk("wr_din",  32'(din8),  32'h1);
    chk("wr_lru",  32'(lout8), 32'h11);
    tick();
    wr8 = 0; hit8 = '0;
    chk("wr_hc", hc8, 32'h2);
    tick(); tick();

    // Dirty miss: victim 7, write-back for 5 cycles, then fetch.
    lin8 = 7'h7F; rd8 = 1; hit8 = '0; val8 = 8'hFF; dty8 = 8'h80; #1;
    chk("miss_resp", 32'(resp8), 32'h0);
    chk("miss_pwr",  32'(pwr8),  32'h0);
    tick();
    chk("wb_mc",    mc8,          32'h1);
    chk("wb_pwr",   32'(pwr8),    32'h1);
    chk("wb_ev",    32'(ev8),     32'h1);
    chk("wb_addrv", 32'(addrv8),  32'h1);
    chk("wb_prd",   32'(prd8),    32'h0);
    lin8 = '0; #1;
    chk("wb_way_latched", 32'(ws8), 32'h7);
    tick(); tick(); tick();
    chk("wb_hold_pwr", 32'(pwr8), 32'h1);
    tick();
    presp8 = 1; #1;
    chk("wb_resp_pwr", 32'(pwr8), 32'h1);
    tick();
    presp8 = 0; #1;
    chk("f_prd",   32'(prd8),   32'h1);
    chk("f_pwr",   32'(pwr8),   32'h0);
    chk("f_addrv", 32'(addrv8), 32'h0);
    chk("f_ev",    32'(ev8),    32'h0);
    chk("f_way",   32'(ws8),    32'h7);
    chk("f_lv",    32'(lv8),    32'h0);
    tick(); tick();
    lin8 = 7'h7F; rd8 = 0; presp8 = 1; #1;
    chk("fr_lv",    32'(lv8),    32'h80);
    chk("fr_ltd",   32'(ltd8),   32'h80);
    chk("fr_ld",    32'(ld8),    32'h80);
    chk("fr_vin",   32'(vin8),   32'h1);
    chk("fr_din",   32'(din8),   32'h0);
    chk("fr_ldlru", 32'(ldlru8), 32'h1);
    chk("fr_lru",   32'(lout8),  32'h3A);
    tick();
    presp8 = 0; #1;
    chk("fr_done_prd", 32'(prd8), 32'h0);
    chk("fr_done_mc",  mc8,       32'h1);
    chk("fr_done_hc",  hc8,       32'h2);

    // 4-way, HIT_STALL=0: non-one-hot hit picks way 1, no stall.
    rd4 = 1; hit4 = 4'b0110; lin4 = '0; #1;
    chk("h4_resp", 32'(resp4), 32'h1);
    chk("h4_way",  32'(ws4),   32'h1);
    chk("h4_lru",  32'(lout4), 32'h1);
    tick();
    chk("h4_resp_nostall", 32'(resp4), 32'h1);
    chk("h4_hc1", 32'(hc4), 32'h1);
    tick();
    rd4 = 0; hit4 = '0; #1;
    chk("h4_hc2", 32'(hc4), 32'h2);

    // 4-way clean valid miss: tree 3'b101 -> victim way 3.
    lin4 = 3'b101; val4 = 4'hF; dty4 = '0; rd4 = 1; #1;
    tick();
    rd4 = 0; #1;
    chk("m4_mc",  32'(mc4),  32'h1);
    chk("m4_pwr", 32'(pwr4), 32'h0);
`ifdef PLRU_VICTIM_EVICT_EN
    chk("m4_ev_ev",    32'(ev4),    32'h1);
    chk("m4_ev_addrv", 32'(addrv4), 32'h1);
    chk("m4_ev_prd",   32'(prd4),   32'h0);
    chk("m4_ev_way",   32'(ws4),    32'h3);
    tick();
`endif
    chk("m4_prd", 32'(prd4), 32'h1);
    chk("m4_ev",  32'(ev4),  32'h0);
    chk("m4_way", 32'(ws4),  32'h3);
    presp4 = 1; #1;
    chk("m4_lv", 32'(lv4), 32'h8);
    tick();
    presp4 = 0; #1;
    chk("m4_done_prd", 32'(prd4), 32'h0);

    // Reset asserted mid-fetch on the 8-way instance (invalid victim way 0).
    lin8 = '0; val8 = '0; dty8 = '0; rd8 = 1; #1;
    tick();
    rd8 = 0; #1;
    chk("d_prd", 32'(prd8), 32'h1);
    chk("d_way", 32'(ws8),  32'h0);
    chk("d_ev",  32'(ev8),  32'h0);
    chk("d_mc",  mc8,       32'h2);
    reset_n = 1'b0; #1;
    chk("d_rst_prd", 32'(prd8), 32'h0);
    chk("d_rst_mc",  mc8,       32'h0);
    chk("d_rst_hc",  hc8,       32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("d_post_prd", 32'(prd8), 32'h0);
    chk("d_post_mc",  mc8,       32'h0);
    rd8 = 1; hit8 = 8'h01; #1;
    chk("d_post_resp", 32'(resp8), 32'h1);
    rd8 = 0; hit8 = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
